mcycle_muldiv: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit. Successor to the ALU's fixed 32-bit

---
 rtl/mcycle_muldiv.sv | 176 +++++++++++++++++
 tb/tb_mcycle_muldiv.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_muldiv.sv
// Multi-cycle signed/unsigned multiply and restoring divide with a Start/Busy/Done handshake.
// Optional build macro MCYCLE_EARLY_TERM_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    // state     | meaning
    // S_IDLE    | waiting for Start
    // S_COMPUTE | one shift-add / restoring-divide iteration per cycle
    // S_DONE    | results valid, Done pulse; Start here is accepted back-to-back

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic                 accept;
    logic                 div_zero;
    logic                 last_iter;
    logic                 s1, s2;
    logic [WIDTH-1:0]     mag1, mag2;

    logic                 op_div;
    logic                 sign_q;
    logic                 sign_r;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     divisor;

    logic [2*WIDTH-1:0]   acc_add;
    logic [WIDTH-1:0]     mplier_sh;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_n;
    logic [WIDTH-1:0]     quo_n;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign accept   = Start && (state != S_COMPUTE);
    assign div_zero = MCycleOp[1] && (Operand2 == '0);
    assign s1       = MCycleOp[0] && Operand1[WIDTH-1];
    assign s2       = MCycleOp[0] && Operand2[WIDTH-1];
    assign mag1     = s1 ? -Operand1 : Operand1;
    assign mag2     = s2 ? -Operand2 : Operand2;

    // Multiplicand shifts left instead of shifting the accumulator right, so an
    // early stop leaves the product already in its final position.
    assign acc_add   = mplier[0] ? acc + mcand : acc;
    assign mplier_sh = mplier >> 1;

    // Partial remainder is kept below the divisor, so bit WIDTH of the difference is the borrow.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, divisor};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_n     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_n     = {quo[WIDTH-2:0], div_ge};

    assign prod_fix = sign_q ? -acc_add : acc_add;
    assign quo_fix  = sign_q ? -quo_n : quo_n;
    assign rem_fix  = sign_r ? -rem_n : rem_n;

`ifdef MCYCLE_EARLY_TERM_EN
    assign last_iter = op_div ? (cnt == CNT_W'(WIDTH - 1)) : (mplier_sh == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_n = div_zero ? S_DONE : S_COMPUTE;
                end else if (state == S_DONE) begin
                    state_n = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (last_iter) begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Result1   <= '0;
            Result2   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            op_div    <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
        end else begin
            Busy <= (state_n == S_COMPUTE);
            Done <= (state_n == S_DONE);
            if (accept) begin
                op_div    <= MCycleOp[1];
                sign_q    <= s1 ^ s2;
                sign_r    <= s1;
                cnt       <= '0;
                acc       <= '0;
                mcand     <= {{WIDTH{1'b0}}, mag1};
                mplier    <= mag2;
                rem       <= '0;
                quo       <= mag1;
                divisor   <= mag2;
                DivByZero <= div_zero;
                if (div_zero) begin
                    Result1 <= '1;
                    Result2 <= Operand1;
                end
            end else if (state == S_COMPUTE) begin
                cnt <= cnt + CNT_W'(1);
                if (op_div) begin
                    rem <= rem_n;
                    quo <= quo_n;
                    if (last_iter) begin
                        Result1 <= quo_fix;
                        Result2 <= rem_fix;
                    end
                end else begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    if (last_iter) begin
                        Result1 <= prod_fix[WIDTH-1:0];
                        Result2 <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mcycle_muldiv.sv
// Self-checking bench for mcycle_muldiv (WIDTH=32): directed vectors, handshake corner cases
// and randomized ops checked against a plain-arithmetic reference model.
module tb_mcycle_muldiv;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    int checks = 0;
    int passes = 0;

    mcycle_muldiv #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Start     (Start),
        .MCycleOp  (MCycleOp),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Result1   (Result1),
        .Result2   (Result2),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference: results from native 64-bit arithmetic, latency counted in edges after the accept edge.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q1, output logic [31:0] q2,
                                      output logic dz, output int lat);
        logic [63:0] up;
        longint      sp;
        logic [31:0] mb;
        dz  = 1'b0;
        lat = 32;
        q1  = '0;
        q2  = '0;
        if (op == 2'b00) begin
            up = {32'b0, a} * {32'b0, b};
            q1 = up[31:0];
            q2 = up[63:32];
        end else if (op == 2'b01) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
            q1 = up[31:0];
            q2 = up[63:32];
        end else if (b == 32'd0) begin
            q1  = 32'hFFFF_FFFF;
            q2  = a;
            dz  = 1'b1;
            lat = 0;
        end else if (op == 2'b10) begin
            q1 = a / b;
            q2 = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q1 = 32'h8000_0000;
            q2 = 32'h0;
        end else begin
            q1 = $signed(a) / $signed(b);
            q2 = $signed(a) % $signed(b);
        end
`ifdef MCYCLE_EARLY_TERM_EN
        if (!op[1]) begin
            mb  = (op[0] && b[31]) ? -b : b;
            lat = 1;
            for (int i = 0; i < 32; i++) if (mb[i]) lat = i + 1;
        end
`else
        mb = b;
`endif
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge on which Done is seen.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r1, output logic [31:0] r2, output logic dz,
                          output int cyc, output int busy_n);
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        @(posedge CLK); #1;
        Start    = 1'b0;
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom);
        cyc      = 0;
        busy_n   = 0;
        while (!Done && cyc <= 100) begin
            if (Busy) busy_n++;
            @(posedge CLK); #1;
            cyc++;
        end
        if (!Done) cyc = -1;
        r1 = Result1;
        r2 = Result2;
        dz = DivByZero;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        #12;
        checks++;
        if ({Result1, Result2, Busy, Done, DivByZero} !== 67'd0)
            $display("FAIL reset_outputs: got r1=%h r2=%h busy=%b done=%b dz=%b, want all zero",
                     Result1, Result2, Busy, Done, DivByZero);
        else passes++;
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if ({Busy, Done} !== 2'b00)
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", Busy, Done);
        else passes++;
    endtask

    task automatic test_mul();
        logic [31:0] r1, r2;
        logic        dz;
        int          cyc, bn;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r1, r2, dz, cyc, bn);
        checks++;
        if ({r2, r1, dz} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0})
            $display("FAIL umul_max: got %h_%h dz=%b, want fffffffe_00000001 dz=0", r2, r1, dz);
        else passes++;
        checks++;
        if (cyc !== 32 || bn !== 32)
            $display("FAIL umul_latency: got done_after=%0d busy_cycles=%0d, want 32 32", cyc, bn);
        else passes++;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, r1, r2, dz, cyc, bn);
        checks++;
        if ({r2, r1} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB})
            $display("FAIL smul_neg3x7: got %h_%h, want ffffffff_ffffffeb", r2, r1);
        else passes++;
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, r1, r2, dz, cyc, bn);
        checks++;
        if ({r2, r1} !== {32'h4000_0000, 32'h0} || cyc !== 32)
            $display("FAIL smul_minxmin: got %h_%h after %0d, want 40000000_00000000 after 32", r2, r1, cyc);
        else passes++;
    endtask

    task automatic test_div();
        logic [31:0] r1, r2;
        logic        dz;
        int          cyc, bn;
        run_op(2'b10, 32'd100, 32'd7, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2, dz} !== {32'd14, 32'd2, 1'b0} || cyc !== 32)
            $display("FAIL udiv_100_7: got q=%h r=%h dz=%b after %0d, want q=e r=2 dz=0 after 32", r1, r2, dz, cyc);
        else passes++;
        run_op(2'b11, 32'hFFFF_FF9C, 32'd7, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE})
            $display("FAIL sdiv_neg100_7: got q=%h r=%h, want q=fffffff2 r=fffffffe", r1, r2);
        else passes++;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2, dz} !== {32'h8000_0000, 32'h0, 1'b0})
            $display("FAIL sdiv_overflow: got q=%h r=%h dz=%b, want q=80000000 r=0 dz=0", r1, r2, dz);
        else passes++;
    endtask

    task automatic test_divzero();
        logic [31:0] r1, r2;
        logic        dz;
        int          cyc, bn;
        run_op(2'b10, 32'h1234_5678, 32'd0, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2, dz} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1} || cyc !== 0 || bn !== 0)
            $display("FAIL udiv_by_zero: got q=%h r=%h dz=%b after %0d busy=%0d, want q=ffffffff r=12345678 dz=1 after 0 busy=0",
                     r1, r2, dz, cyc, bn);
        else passes++;
        run_op(2'b11, 32'hFFFF_FF9C, 32'd0, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2, dz} !== {32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1} || cyc !== 0)
            $display("FAIL sdiv_by_zero: got q=%h r=%h dz=%b after %0d, want q=ffffffff r=ffffff9c dz=1 after 0",
                     r1, r2, dz, cyc);
        else passes++;
        // Accept in the Done cycle of the divide-by-zero; the flag must drop on that accept.
        MCycleOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd4; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        checks++;
        if ({DivByZero, Busy, Done} !== 3'b010)
            $display("FAIL dz_clear_on_accept: got dz=%b busy=%b done=%b, want 0 1 0", DivByZero, Busy, Done);
        else passes++;
        cyc = 0;
        while (!Done && cyc <= 100) begin @(posedge CLK); #1; cyc++; end
        ref_model(2'b00, 32'd3, 32'd4, r1, r2, dz, bn);
        checks++;
        if ({Result1, Result2, DivByZero} !== {r1, r2, 1'b0} || cyc !== bn)
            $display("FAIL mul_after_dz: got %h_%h dz=%b after %0d, want %h_%h dz=0 after %0d",
                     Result2, Result1, DivByZero, cyc, r2, r1, bn);
        else passes++;
    endtask

    task automatic test_busy_ignore();
        logic [31:0] e1, e2;
        logic        edz;
        int          elat, cyc;
        ref_model(2'b00, 32'd1234, 32'd5678, e1, e2, edz, elat);
        MCycleOp = 2'b00; Operand1 = 32'd1234; Operand2 = 32'd5678; Start = 1'b1;
        @(posedge CLK); #1;
        cyc = 0;
        while (!Done && cyc <= 100) begin
            Start = (cyc >= 5 && cyc <= 8);
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = 2'b11;
            @(posedge CLK); #1;
            cyc++;
        end
        Start = 1'b0;
        checks++;
        if ({Result1, Result2} !== {e1, e2} || cyc !== elat)
            $display("FAIL start_while_busy: got r1=%h r2=%h after %0d, want r1=%h r2=%h after %0d",
                     Result1, Result2, cyc, e1, e2, elat);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, e1, e2;
        logic        dz, edz;
        int          cyc, bn, elat;
        run_op(2'b10, 32'd1000, 32'd33, a1, a2, dz, cyc, bn);
        ref_model(2'b01, 32'hFFFF_FC18, 32'd77, e1, e2, edz, elat);
        MCycleOp = 2'b01; Operand1 = 32'hFFFF_FC18; Operand2 = 32'd77; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        checks++;
        if ({Done, Busy} !== 2'b01 || {Result1, Result2} !== {32'd30, 32'd10})
            $display("FAIL b2b_accept: got done=%b busy=%b r1=%h r2=%h, want 0 1 r1=1e r2=a",
                     Done, Busy, Result1, Result2);
        else passes++;
        cyc = 0;
        while (!Done && cyc <= 100) begin @(posedge CLK); #1; cyc++; end
        checks++;
        if ({Result1, Result2} !== {e1, e2} || cyc !== elat)
            $display("FAIL b2b_second: got r1=%h r2=%h after %0d, want r1=%h r2=%h after %0d",
                     Result1, Result2, cyc, e1, e2, elat);
        else passes++;
        @(posedge CLK); #1;
        checks++;
        if ({Done, Busy} !== 2'b00)
            $display("FAIL done_pulse: got done=%b busy=%b one cycle later, want 0 0", Done, Busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r1, r2;
        logic        dz;
        int          cyc, bn, dones;
        run_op(2'b10, 32'd100, 32'd7, r1, r2, dz, cyc, bn);
        MCycleOp = 2'b00; Operand1 = 32'hFFFF_FFFF; Operand2 = 32'hFFFF_FFFF; Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) begin @(posedge CLK); #1; end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Result1, Result2, Busy, Done, DivByZero} !== 67'd0)
            $display("FAIL reset_mid_op: got r1=%h r2=%h busy=%b done=%b dz=%b, want all zero",
                     Result1, Result2, Busy, Done, DivByZero);
        else passes++;
        @(posedge CLK); #1;
        Reset = 1'b0;
        dones = 0;
        repeat (40) begin @(posedge CLK); #1; if (Done || Busy) dones++; end
        checks++;
        if (dones !== 0)
            $display("FAIL no_done_after_reset: got %0d busy/done cycles, want 0", dones);
        else passes++;
        run_op(2'b11, 32'hFFFF_FF9C, 32'd7, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE} || cyc !== 32)
            $display("FAIL first_op_after_reset: got q=%h r=%h after %0d, want q=fffffff2 r=fffffffe after 32",
                     r1, r2, cyc);
        else passes++;
    endtask

    task automatic test_early_term();
        logic [31:0] r1, r2;
        logic        dz;
        int          cyc, bn, want5x3, want0;
`ifdef MCYCLE_EARLY_TERM_EN
        want5x3 = 2;
        want0   = 1;
`else
        want5x3 = 32;
        want0   = 32;
`endif
        run_op(2'b00, 32'd5, 32'd3, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2} !== {32'd15, 32'd0} || cyc !== want5x3)
            $display("FAIL mul_5x3_timing: got r1=%h r2=%h after %0d, want r1=f r2=0 after %0d",
                     r1, r2, cyc, want5x3);
        else passes++;
        run_op(2'b01, 32'hDEAD_BEEF, 32'd0, r1, r2, dz, cyc, bn);
        checks++;
        if ({r1, r2} !== 64'd0 || cyc !== want0)
            $display("FAIL mul_by_zero_timing: got r1=%h r2=%h after %0d, want 0 0 after %0d",
                     r1, r2, cyc, want0);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r1, r2, e1, e2;
        logic [1:0]  op;
        logic        dz, edz;
        int          cyc, bn, elat;
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = specials[$urandom_range(0, 5)];
                1:       b = 32'($urandom_range(0, 255));
                default: b = 32'($urandom);
            endcase
            ref_model(op, a, b, e1, e2, edz, elat);
            run_op(op, a, b, r1, r2, dz, cyc, bn);
            checks++;
            if ({r1, r2, dz} !== {e1, e2, edz} || cyc !== elat)
                $display("FAIL random_op%0d: op=%b a=%h b=%h got r1=%h r2=%h dz=%b after %0d, want r1=%h r2=%h dz=%b after %0d",
                         i, op, a, b, r1, r2, dz, cyc, e1, e2, edz, elat);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_early_term();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
